// File: rtl/arb_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arb_mux_pkg
// Description : Shared definitions for the arb_mux arbitrating multiplexer:
//               arbitration mode encodings and select-width derivation.
// Revision    : 1.0 - initial release
// ============================================================================
package arb_mux_pkg;

  // Arbitration mode encodings understood by rr_arbiter
  localparam logic ARB_RR    = 1'b0;
  localparam logic ARB_FIXED = 1'b1;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational request-to-one-hot grant. Round-robin search
//               begins at i_ptr+1 and wraps; fixed mode picks lowest index.
// Ports       : i_req   - per-channel request vector
//               i_ptr   - index of the most recently granted channel
//               i_mode  - ARB_RR or ARB_FIXED
//               o_grant - one-hot grant, zero when no request
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import arb_mux_pkg::*;
#(
  parameter int NUM_IN = 3,
  parameter int SEL_W  = 2
) (
  input  logic [NUM_IN-1:0] i_req,
  input  logic [SEL_W-1:0]  i_ptr,
  input  logic              i_mode,
  output logic [NUM_IN-1:0] o_grant
);

  logic [NUM_IN-1:0] w_mask;
  logic [NUM_IN-1:0] w_req_hi;
  logic [NUM_IN-1:0] w_gnt_hi;
  logic [NUM_IN-1:0] w_gnt_all;

  // Channels strictly above the pointer are searched first.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      w_mask[i] = (SEL_W'(i) > i_ptr);
    end
  end

  // Lowest set bit isolation: x & -x
  assign w_req_hi  = i_req & w_mask;
  assign w_gnt_hi  = w_req_hi & (~w_req_hi + NUM_IN'(1));
  assign w_gnt_all = i_req & (~i_req + NUM_IN'(1));

  // With nothing above the pointer the search wraps to the lowest index.
  assign o_grant = (i_mode == ARB_FIXED) ? w_gnt_all :
                   ((|w_req_hi) ? w_gnt_hi : w_gnt_all);

endmodule
`default_nettype wire

// File: rtl/arb_mux.sv
`default_nettype none
// ============================================================================
// Module      : arb_mux
// Description : N-input valid/ready multiplexer with round-robin, fixed
//               priority or forced-channel arbitration and a one-entry
//               registered output stage.
// Ports       : I_clk/I_rst          - clock, async active-high reset
//               I_valid/O_ready/I_data - per-channel input handshake + data
//               I_force_en/I_force_sel - restrict grant to one channel
//               O_valid/I_ready/O_data/O_sel - output handshake, data, source
// Revision    : 1.0 - initial release
// ============================================================================
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter int NUM_IN     = 3,
  parameter int WIDTH      = 32,
  parameter int FIXED_PRIO = 0,
  localparam int SEL_W     = sel_w(NUM_IN)
) (
  input  logic                    I_clk,
  input  logic                    I_rst,
  input  logic [NUM_IN-1:0]       I_valid,
  output logic [NUM_IN-1:0]       O_ready,
  input  logic [NUM_IN*WIDTH-1:0] I_data,
  input  logic                    I_force_en,
  input  logic [SEL_W-1:0]        I_force_sel,
  output logic                    O_valid,
  input  logic                    I_ready,
  output logic [WIDTH-1:0]        O_data,
  output logic [SEL_W-1:0]        O_sel
);

  localparam logic c_mode = (FIXED_PRIO != 0) ? ARB_FIXED : ARB_RR;

  logic              r_valid;
  logic [WIDTH-1:0]  r_data;
  logic [SEL_W-1:0]  r_sel;
  logic [SEL_W-1:0]  r_ptr;

  logic              w_load;
  logic [NUM_IN-1:0] w_force_mask;
  logic [NUM_IN-1:0] w_req;
  logic [NUM_IN-1:0] w_grant;
  logic [SEL_W-1:0]  w_gsel;
  logic [WIDTH-1:0]  w_gdata;

  // Output register can take a beat when empty or draining this cycle.
  assign w_load = ~r_valid | I_ready;

  // An out-of-range force index matches no channel, so nothing is granted.
  always_comb begin
    w_force_mask = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      w_force_mask[i] = (SEL_W'(i) == I_force_sel);
    end
  end

  assign w_req = I_valid
               & (I_force_en ? w_force_mask : {NUM_IN{1'b1}})
               & {NUM_IN{w_load & ~I_rst}};

  rr_arbiter #(
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_arb (
    .i_req   (w_req),
    .i_ptr   (r_ptr),
    .i_mode  (c_mode),
    .o_grant (w_grant)
  );

  assign O_ready = w_grant;

  // One-hot grant lets index and data be formed by plain AND-OR.
  always_comb begin
    w_gsel  = '0;
    w_gdata = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      w_gsel  = w_gsel  | (SEL_W'(i) & {SEL_W{w_grant[i]}});
      w_gdata = w_gdata | (I_data[i*WIDTH +: WIDTH] & {WIDTH{w_grant[i]}});
    end
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= '0;
      r_ptr   <= SEL_W'(NUM_IN - 1);
    end else begin
      if (|w_grant) begin
        r_valid <= 1'b1;
        r_data  <= w_gdata;
        r_sel   <= w_gsel;
        if (c_mode == ARB_RR) begin
          r_ptr <= w_gsel;
        end
      end else if (r_valid && I_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign O_valid = r_valid;
  assign O_data  = r_data;
  assign O_sel   = r_sel;

endmodule
`default_nettype wire

// File: tb/tb_arb_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_arb_mux
// Description : Directed testbench for arb_mux. One round-robin instance and
//               one fixed-priority instance; expected output beats are queued
//               at stimulus time and compared by per-instance monitors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arb_mux;

  localparam int N  = 3;
  localparam int W  = 32;
  localparam int SW = 2;

  typedef struct packed {
    logic [SW-1:0] sel;
    logic [W-1:0]  data;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N*W-1:0] data;

  // Round-robin instance
  logic [N-1:0]  v0, ordy0;
  logic          fe0, ir0, ov0;
  logic [SW-1:0] fs0, osel0;
  logic [W-1:0]  od0;

  // Fixed-priority instance
  logic [N-1:0]  v1, ordy1;
  logic          fe1, ir1, ov1;
  logic [SW-1:0] fs1, osel1;
  logic [W-1:0]  od1;

  arb_mux #(.NUM_IN(N), .WIDTH(W), .FIXED_PRIO(0)) dut0 (
    .I_clk(clk), .I_rst(rst), .I_valid(v0), .O_ready(ordy0), .I_data(data),
    .I_force_en(fe0), .I_force_sel(fs0), .O_valid(ov0), .I_ready(ir0),
    .O_data(od0), .O_sel(osel0)
  );

  arb_mux #(.NUM_IN(N), .WIDTH(W), .FIXED_PRIO(1)) dut1 (
    .I_clk(clk), .I_rst(rst), .I_valid(v1), .O_ready(ordy1), .I_data(data),
    .I_force_en(fe1), .I_force_sel(fs1), .O_valid(ov1), .I_ready(ir1),
    .O_data(od1), .O_sel(osel1)
  );

  beat_t q0[$];
  beat_t q1[$];
  beat_t e0, e1;
  int errors = 0;
  int checks = 0;

  localparam logic [W-1:0] DA = 32'hA0;
  localparam logic [W-1:0] DB = 32'hB1;
  localparam logic [W-1:0] DC = 32'hC2;
  localparam logic [W-1:0] DD = 32'hD3;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push0(input logic [SW-1:0] s, input logic [W-1:0] d);
    q0.push_back('{sel: s, data: d});
  endtask

  task automatic push1(input logic [SW-1:0] s, input logic [W-1:0] d);
    q1.push_back('{sel: s, data: d});
  endtask

  // Monitors: a beat is consumed at the next rising edge when valid & ready.
  always @(negedge clk) begin
    if (ov0 && ir0) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rr_unexpected_beat: got sel=%0d data=%0h, required no beat", osel0, od0);
      end else begin
        e0 = q0.pop_front();
        check("rr_sel", 64'(osel0), 64'(e0.sel));
        check("rr_data", 64'(od0), 64'(e0.data));
      end
    end
  end

  always @(negedge clk) begin
    if (ov1 && ir1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL fp_unexpected_beat: got sel=%0d data=%0h, required no beat", osel1, od1);
      end else begin
        e1 = q1.pop_front();
        check("fp_sel", 64'(osel1), 64'(e1.sel));
        check("fp_data", 64'(od1), 64'(e1.data));
      end
    end
  end

  initial begin
    rst  = 1'b1;
    data = {DC, DB, DA};
    v0 = '0; fe0 = 1'b0; fs0 = '0; ir0 = 1'b1;
    v1 = '0; fe1 = 1'b0; fs1 = '0; ir1 = 1'b1;

    // Reset state
    #2;
    check("reset_valid", 64'(ov0), 64'd0);
    check("reset_data", 64'(od0), 64'd0);
    check("reset_sel", 64'(osel0), 64'd0);
    check("reset_ready_idle", 64'(ordy0), 64'd0);
    v0 = 3'b111;
    #1;
    check("reset_ready_req", 64'(ordy0), 64'd0);
    v0 = '0;
    tick();
    rst = 1'b0;
    #1;
    check("idle_valid", 64'(ov0), 64'd0);
    check("idle_ready", 64'(ordy0), 64'd0);
    tick();

    // Round-robin fairness, one beat per cycle
    v0 = 3'b111;
    #1;
    check("rr_first_grant", 64'(ordy0), 64'b001);
    for (int k = 0; k < 5; k++) begin
      case (k % 3)
        0: push0(2'd0, DA);
        1: push0(2'd1, DB);
        default: push0(2'd2, DC);
      endcase
      tick();
    end
    ir0 = 1'b0;

    // Backpressure: hold B1 for four cycles
    for (int k = 0; k < 4; k++) begin
      #1;
      check("bp_ready", 64'(ordy0), 64'd0);
      check("bp_data", 64'(od0), 64'(DB));
      check("bp_sel", 64'(osel0), 64'd1);
      check("bp_valid", 64'(ov0), 64'd1);
      tick();
    end
    ir0 = 1'b1;
    #1;
    check("bp_release_grant", 64'(ordy0), 64'b100);
    push0(2'd2, DC);
    tick();

    // Pointer wrap and single requester
    v0 = 3'b001;
    #1;
    check("wrap_grant0", 64'(ordy0), 64'b001);
    push0(2'd0, DA);
    tick();
    v0 = 3'b101;
    #1;
    check("search_from_ptr", 64'(ordy0), 64'b100);
    push0(2'd2, DC);
    tick();

    // Force mode
    fe0 = 1'b1; fs0 = 2'd2; v0 = 3'b011;
    #1;
    check("force_idle_ready", 64'(ordy0), 64'd0);
    tick();
    check("force_idle_drain", 64'(ov0), 64'd0);
    data = {DD, DB, DA};
    v0 = 3'b111;
    #1;
    check("force_ch2_ready", 64'(ordy0), 64'b100);
    push0(2'd2, DD);
    tick();
    fs0 = 2'd0;
    #1;
    check("force_ch0_ready", 64'(ordy0), 64'b001);
    push0(2'd0, DA);
    tick();
    fs0 = 2'd3;
    #1;
    check("force_oob_ready", 64'(ordy0), 64'd0);
    tick();
    check("force_oob_drain", 64'(ov0), 64'd0);

    // Pointer was moved to 0 by the forced grant
    fe0 = 1'b0;
    #1;
    check("force_ptr_update", 64'(ordy0), 64'b010);
    push0(2'd1, DB);
    tick();
    ir0 = 1'b0;

    // Asynchronous reset while holding a beat
    #1;
    check("pre_reset_valid", 64'(ov0), 64'd1);
    rst = 1'b1;
    #1;
    check("async_rst_valid", 64'(ov0), 64'd0);
    check("async_rst_data", 64'(od0), 64'd0);
    check("async_rst_sel", 64'(osel0), 64'd0);
    check("async_rst_ready", 64'(ordy0), 64'd0);
    q0.delete();
    tick();
    rst = 1'b0;
    ir0 = 1'b1;
    #1;
    check("post_rst_ptr", 64'(ordy0), 64'b001);
    push0(2'd0, DA);
    tick();
    v0 = '0;
    tick();
    tick();

    // Fixed priority instance
    data = {DC, DB, DA};
    v1 = 3'b110;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("fp_ready_110", 64'(ordy1), 64'b010);
      push1(2'd1, DB);
      tick();
    end
    v1 = 3'b100;
    #1;
    check("fp_ready_100", 64'(ordy1), 64'b100);
    push1(2'd2, DC);
    tick();
    v1 = '0;
    tick();
    tick();

    check("rr_queue_empty", 64'(q0.size()), 64'd0);
    check("fp_queue_empty", 64'(q1.size()), 64'd0);
    check("end_valid", 64'(ov0), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/arb_mux.md
Name: arb_mux

Overview:
- Parametrised N-input, W-bit multiplexer with valid/ready handshakes on every input and on the output, plus a one-entry registered output stage.
- Selects among requesting channels by round-robin (default), fixed priority, or a forced channel select.
- Sits between multiple bus masters or result sources (fetch/LSU/DMA, writeback sources) and a single shared consumer in the CPU/SoC datapath.

Parameters:
NUM_IN, 3, number of input channels (2..16)
WIDTH, 32, data width per channel
FIXED_PRIO, 0, 0 = round-robin arbitration; 1 = fixed priority, lowest index wins

Ports:
I_clk  input  1  clock, rising edge
I_rst  input  1  reset, asynchronous, active-high
I_valid  input  NUM_IN  per-channel request/valid
O_ready  output  NUM_IN  per-channel accept; beat i transfers when I_valid[i] & O_ready[i]
I_data  input  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
I_force_en  input  1  1 = only channel I_force_sel may be granted
I_force_sel  input  SEL_W  forced channel index, SEL_W = max(1, clog2(NUM_IN))
O_valid  output  1  output register holds a beat
I_ready  input  1  consumer accepts; output beat transfers when O_valid & I_ready
O_data  output  WIDTH  registered selected data
O_sel  output  SEL_W  index of the channel that supplied O_data

Behaviour:
- Reset (async assert, I_rst=1): O_valid=0, O_data=0, O_sel=0, round-robin pointer=NUM_IN-1, so channel 0 has first priority. O_ready=0 while I_rst=1.
- Load enable: load = ~O_valid | I_ready. Combinational path from I_ready to O_ready is permitted; no path from O_ready to I_valid.
- Grant, combinational, one-hot or zero; only computed when load=1, else zero:
  - Force mode (I_force_en=1): grant channel I_force_sel if I_valid[I_force_sel]=1. No grant if that channel is idle or I_force_sel >= NUM_IN. Other channels are never granted in force mode.
  - FIXED_PRIO=1: lowest-index channel with I_valid=1.
  - Round-robin: first requesting channel searching upward from (pointer+1) mod NUM_IN, wrapping past NUM_IN-1 to 0.
- O_ready[i] = grant[i].
- On a clock edge with any grant to channel g: O_data <= I_data[g], O_sel <= g, O_valid <= 1.
  - The round-robin pointer becomes g. The pointer updates in force mode as well; it never updates in FIXED_PRIO mode.
- On a clock edge with no grant: if O_valid & I_ready, O_valid <= 0. O_data and O_sel hold their last values.
- Latency: input beat to O_valid is 1 cycle. Throughput is 1 beat/cycle when I_ready is held high.
- Stability: while O_valid=1 and I_ready=0, O_data and O_sel hold and all O_ready are 0.
- Simultaneous drain and load in the same cycle: the register is replaced by the new beat with no bubble.
- I_valid dropping without a handshake is legal. Arbitration re-evaluates every cycle; there is no grant lock.
- Reset mid-transfer: the held beat is discarded and the pointer is reinitialised. Sources must re-present their data.
- NUM_IN=1 degenerates to a registered pipeline stage with SEL_W=1 and O_sel always 0.

Decomposition:
- Shared package:
  - SEL_W derivation function (clog2 with minimum 1).
  - Arbitration mode constants ARB_RR=0 and ARB_FIXED=1.
- One sub-module, rr_arbiter: a purely combational NUM_IN-wide requester-to-one-hot grant block with a pointer input and a mode input.
  - The arbiter pointer register lives in arb_mux.
- Data selection is an AND-OR over the one-hot grant; no priority encoder is needed on the data path.

Test Plan:
- Reset then idle: I_valid=000 -> O_valid=0, O_data=0, O_sel=0, O_ready=000. Assert I_rst mid-beat -> O_valid=0 immediately, without a clock edge.
- Round-robin fairness: NUM_IN=3, I_valid=111 held, I_ready=1, data 0xA0/0xB1/0xC2 -> O_sel sequence 0,1,2,0,1,2 one per cycle, O_data 0xA0,0xB1,0xC2,...
- Backpressure: O_valid=1 holding 0xB1, I_ready=0 for 4 cycles with I_valid=111 -> O_data stays 0xB1, O_ready=000. Then I_ready=1 -> next grant is channel 2 in the same cycle.
- Fixed priority: FIXED_PRIO=1, I_valid=110 held, I_ready=1 -> O_sel=1 every cycle and channel 2 is never granted. With I_valid=100 -> O_sel=2.
- Force mode: I_force_en=1, I_force_sel=2, I_valid=011 -> no grant, O_valid falls to 0 after drain. I_valid=111 -> O_sel=2, O_data=I_data[2]. I_force_sel=3 with NUM_IN=3 -> no grant.
- Pointer wrap and single requester: after a grant to channel 2, I_valid=001 -> grant channel 0. Then I_valid=101 -> grant channel 2 next, proving the search starts at pointer+1.
